seg7_scan_decoder: RTL

//  Receive-side counterpart of the hex-to-7-segment encoder.
//  - Samples a multiplexed 4-digit 7-segment bus (segment lines plus one-hot digit enables).
//  - Waits for each digit's pattern to be stable, then decodes it back to a hex nibble.
//  - Holds the four recovered nibbles and flags complete frames and illegal patterns.

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/seg7_scan_decoder_if.sv | 19 +
 rtl/seg7_pattern_decode.sv | 23 ++
 rtl/seg7_scan_decoder.sv | 139 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan decoder.
// Holds the segment pattern table (g..a), FSM state encodings, the captured
// bus sample type and small one-hot helpers.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Entry n is the pattern for hex digit n; bit 0 = segment a, bit 6 = g.
    localparam logic [15:0][6:0] SEG_PAT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    typedef struct packed {
        logic [NUM_DIGITS-1:0] an;
        logic [6:0]            seg;
    } bus_sample_t;

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return $countones(v) == 1;
    endfunction

    // Index of the set bit; only meaningful when v is one-hot.
    function automatic logic [1:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (v[i]) idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_if: multiplexed display bus plus the recovered-digit outputs.
// Optional SEG7_ERR_COUNT_EN adds the err_count signal.
interface seg7_scan_if;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        err;
`ifdef SEG7_ERR_COUNT_EN
    logic [7:0]  err_count;

    modport master (output seg, an, input digits, digit_valid, frame_done, err, err_count);
    modport slave  (input seg, an, output digits, digit_valid, frame_done, err, err_count);
`else
    modport master (output seg, an, input digits, digit_valid, frame_done, err);
    modport slave  (input seg, an, output digits, digit_valid, frame_done, err);
`endif
endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational lookup of a 7-segment pattern back to
// its hex nibble; legal is low for any pattern outside the table.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] nibble
);

    // Linear search of the 16-entry table; patterns are unique so at most one hits.
    always_comb begin
        legal  = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_PAT[i]) begin
                legal  = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: snoops a multiplexed 4-digit 7-segment bus, waits for
// each digit dwell to be stable for STABLE_CYCLES samples, decodes it and
// holds the recovered nibbles. Flags completed frames and illegal patterns.
// Optional SEG7_ERR_COUNT_EN adds a saturating 8-bit err_count.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);

    localparam logic [7:0] STB = 8'(STABLE_CYCLES);

    bus_sample_t          in_q, in_prev;
    state_t               state, state_n;
    logic [7:0]           cnt, cnt_n;
    logic                 capture;
    logic                 changed, onehot, legal;
    logic [3:0]           nibble;
    logic [1:0]           idx;
    logic                 cap_ok, cap_bad;
    logic [NUM_DIGITS-1:0][3:0] digits_q;
    logic [NUM_DIGITS-1:0] valid_q, frame_mask, mask_base;
    logic                 frame_done_q, err_q;

    seg7_pattern_decode u_dec (
        .seg    (in_q.seg),
        .legal  (legal),
        .nibble (nibble)
    );

    assign changed = (in_q != in_prev);
    assign onehot  = is_onehot(in_q.an);
    assign idx     = onehot_idx(in_q.an);

    // Register the pins once, and keep the previous sample for change detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q    <= '0;
            in_prev <= '0;
        end else begin
            in_q    <= '{an: bus.an, seg: bus.seg};
            in_prev <= in_q;
        end
    end

    // FSM state and stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_WAIT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: restart counting on any change, capture when the count reaches STB.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            ST_WAIT: begin
                if (onehot) begin
                    state_n = ST_COUNT;
                    cnt_n   = 8'd1;
                end
            end
            ST_COUNT, ST_LOCKED: begin
                if (changed) begin
                    state_n = onehot ? ST_COUNT : ST_WAIT;
                    cnt_n   = onehot ? 8'd1 : 8'd0;
                end else if (state == ST_COUNT && cnt != STB) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = ST_WAIT;
                cnt_n   = '0;
            end
        endcase
        // Covers STB==1 too, where the first sample of a dwell already qualifies.
        if (state_n == ST_COUNT && cnt_n == STB) begin
            capture = 1'b1;
            state_n = ST_LOCKED;
        end
    end

    // Split the capture into legal / illegal and compute the mask after a completed frame clears.
    always_comb begin
        cap_ok    = capture & legal;
        cap_bad   = capture & ~legal;
        mask_base = (frame_mask == '1) ? '0 : frame_mask;
    end

    // Capture registers, frame mask and the two pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q     <= '0;
            valid_q      <= '0;
            frame_mask   <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q        <= cap_bad;
            frame_done_q <= (frame_mask == '1);
            frame_mask   <= mask_base;
            if (cap_ok) begin
                digits_q[idx]   <= nibble;
                valid_q[idx]    <= 1'b1;
                frame_mask[idx] <= 1'b1;
            end else if (cap_bad) begin
                valid_q[idx] <= 1'b0;
            end
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.err         = err_q;

`ifdef SEG7_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of err pulses.
    always_ff @(posedge clk) begin
        if (rst)                        err_cnt_q <= '0;
        else if (err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign bus.err_count = err_cnt_q;
`endif

endmodule
